// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one single-outstanding bus between instruction fetch (IF)
// and load/store (MEM); MEM has priority, and IF is forced through after two lost grants.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ready,
  output logic                bus_cyc,
  output logic                bus_stb,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                stallreq_if,
  output logic                stallreq_mem,
  output logic [1:0]          dbg_state
);

  // Handshake: a requester holds *_req and its payload until the matching *_ready
  // pulse; the bus request is held stable from bus_cyc rise until the bus_ack cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  state_t     state_q, state_d;
  logic       owner_q;
  logic       discard_q, discard_d;
  logic [1:0] loss_q, loss_d;
  logic       grant_if, grant_mem, capture;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    loss_d    = loss_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (!flush) begin
          if (if_req && (loss_q == 2'd2 || !mem_req)) grant_if = 1'b1;
          else if (mem_req)                             grant_mem = 1'b1;
        end
        if (grant_if) begin
          state_d = BUSY_IF;
          loss_d  = 2'd0;
        end else if (grant_mem) begin
          state_d = BUSY_MEM;
          if (if_req && loss_q != 2'd2) loss_d = loss_q + 2'd1;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        // A flushed transfer still runs to its ack; only the ready pulse is dropped.
        if (flush) discard_d = 1'b1;
        if (bus_ack && bus_cyc) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      discard_q <= 1'b0;
      loss_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      loss_q    <= loss_d;
      if (grant_if)       owner_q <= OWN_IF;
      else if (grant_mem) owner_q <= OWN_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_cyc   <= 1'b0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if (grant_if) begin
        bus_cyc   <= 1'b1;
        bus_stb   <= 1'b1;
        bus_we    <= 1'b0;
        bus_sel   <= '1;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
      end else if (grant_mem) begin
        bus_cyc   <= 1'b1;
        bus_stb   <= 1'b1;
        bus_we    <= mem_we;
        bus_sel   <= mem_sel;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
      end
      if (capture) begin
        bus_cyc <= 1'b0;
        bus_stb <= 1'b0;
        if (owner_q == OWN_MEM) mem_rdata <= bus_rdata;
        else                    if_rdata  <= bus_rdata;
      end
    end
  end

  assign if_ready  = (state_q == RESP) && (owner_q == OWN_IF)  && !discard_q && !flush;
  assign mem_ready = (state_q == RESP) && (owner_q == OWN_MEM) && !discard_q && !flush;

  // Gated by rst so every output reads 0 while reset is held.
  assign stallreq_if  = rst & if_req  & ~if_ready;
  assign stallreq_mem = rst & mem_req & ~mem_ready;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted IF/MEM requesters, a bus slave that checks each
// granted request against an expected queue, and cycle-latency/flush/reset checks.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int BW = 1 + SW + AW + DW;
  localparam logic [DW-1:0] KEY = 32'h3C01_0101;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          if_req, if_ready, mem_req, mem_we, mem_ready;
  logic [AW-1:0] if_addr, mem_addr, bus_addr;
  logic [DW-1:0] if_rdata, mem_wdata, mem_rdata, bus_wdata, bus_rdata;
  logic [SW-1:0] mem_sel, bus_sel;
  logic          bus_cyc, bus_stb, bus_we, bus_ack;
  logic          stallreq_if, stallreq_mem;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [BW-1:0] exp_q[$];

  int ack_dly   = 0;
  bit slave_en  = 1'b1;
  bit stray_ack = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [BW-1:0] bus_word();
    return {bus_we, bus_sel, bus_addr, bus_wdata};
  endfunction

  task automatic push_if(input logic [AW-1:0] addr);
    exp_q.push_back({1'b0, {SW{1'b1}}, addr, {DW{1'b0}}});
  endtask

  task automatic push_mem(input logic we, input logic [SW-1:0] sel,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_q.push_back({we, sel, addr, wdata});
  endtask

  // bus slave: acks ack_dly cycles after stb, returns addr ^ KEY, pops scoreboard
  initial begin
    int wait_cnt;
    logic [BW-1:0] first;
    wait_cnt  = 0;
    first     = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_ack = stray_ack;
      if (slave_en && bus_cyc && bus_stb) begin
        if (wait_cnt == 0) first = bus_word();
        else check("bus_hold", bus_word(), first);
        if (wait_cnt == ack_dly) begin
          bus_ack   = 1'b1;
          bus_rdata = bus_addr ^ KEY;
          wait_cnt  = 0;
          check("bus_q_empty", exp_q.size() == 0, 0);
          if (exp_q.size() != 0) check("bus_req", first, exp_q.pop_front());
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // driver tasks
  task automatic if_txn(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                        output int lat);
    if_addr = addr;
    if_req  = 1'b1;
    lat     = 0;
    do begin
      @(posedge clk); #2;
      lat++;
      if (lat == 1) check("stall_if_wait", stallreq_if, 1);
    end while (!if_ready && lat < 60);
    check("if_ready", if_ready, 1);
    check("if_rdata", if_rdata, exp_data);
    check("stall_if_ready_cyc", stallreq_if, 0);
    @(posedge clk); #1;
    if_req = 1'b0;
    #1 check("if_ready_pulse", if_ready, 0);
  endtask

  task automatic mem_txn(input logic we, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data,
                         input bit keep, output int lat);
    mem_we    = we;
    mem_sel   = sel;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_req   = 1'b1;
    lat       = 0;
    do begin
      @(posedge clk); #2;
      lat++;
      if (lat == 1) check("stall_mem_wait", stallreq_mem, 1);
    end while (!mem_ready && lat < 60);
    check("mem_ready", mem_ready, 1);
    check("mem_rdata", mem_rdata, exp_data);
    check("stall_mem_ready_cyc", stallreq_mem, 0);
    @(posedge clk); #1;
    if (!keep) mem_req = 1'b0;
    #1 check("mem_ready_pulse", mem_ready, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // scenarios
  initial begin
    int l1, l2, n, ready_cnt, cyc_cnt;
    rst = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #2 check("reset_outputs", {bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata,
                               if_rdata, mem_rdata, if_ready, mem_ready, stallreq_if,
                               stallreq_mem, dbg_state}, 0);
    #1 rst = 1'b1;

    // IF read with slow ack
    ack_dly = 2;
    push_if(32'h0000_0100);
    if_txn(32'h0000_0100, 32'h3C01_0001, l1);
    check("if_lat_ack2", l1, 4);

    // minimum latency, then rdata hold across the other requester
    ack_dly = 0;
    push_if(32'h0000_0104);
    if_txn(32'h0000_0104, 32'h0000_0104 ^ KEY, l1);
    check("if_lat_min", l1, 2);
    push_mem(1'b0, 4'hF, 32'h0000_0300, 32'h0000_0077);
    mem_txn(1'b0, 4'hF, 32'h0000_0300, 32'h0000_0077, 32'h0000_0300 ^ KEY, 1'b0, l1);
    check("mem_lat_min", l1, 2);
    check("if_rdata_hold", if_rdata, 32'h0000_0104 ^ KEY);

    // simultaneous requests: MEM store first, then IF
    ack_dly = 1;
    push_mem(1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
    push_if(32'h0000_0108);
    fork
      mem_txn(1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0200 ^ KEY, 1'b0, l1);
      if_txn(32'h0000_0108, 32'h0000_0108 ^ KEY, l2);
    join
    check("simul_mem_lat", l1, 3);
    check("simul_if_lat", l2, 7);

    // fairness: two MEM grants, then IF forced in ahead of the third MEM
    do_reset();
    ack_dly = 0;
    push_mem(1'b0, 4'h3, 32'h0000_0400, 32'h11);
    push_mem(1'b0, 4'h3, 32'h0000_0404, 32'h11);
    push_if(32'h0000_010C);
    push_mem(1'b0, 4'h3, 32'h0000_0408, 32'h11);
    fork
      begin
        mem_txn(1'b0, 4'h3, 32'h0000_0400, 32'h11, 32'h0000_0400 ^ KEY, 1'b1, l1);
        mem_txn(1'b0, 4'h3, 32'h0000_0404, 32'h11, 32'h0000_0404 ^ KEY, 1'b1, l1);
        mem_txn(1'b0, 4'h3, 32'h0000_0408, 32'h11, 32'h0000_0408 ^ KEY, 1'b0, l1);
      end
      if_txn(32'h0000_010C, 32'h0000_010C ^ KEY, l2);
    join
    check("fair_if_lat", l2, 8);

    // flush during BUSY_IF: transfer completes, no ready pulse
    ack_dly = 3;
    push_if(32'h0000_0040);
    if_addr = 32'h0000_0040;
    if_req  = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!bus_cyc && n < 20);
    check("flush_busy_if", dbg_state, 2'd1);
    flush = 1'b1; if_req = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (i == 0) begin
        flush = 1'b0;
        check("flush_cyc_held", bus_cyc, 1);
      end
      if (if_ready) ready_cnt++;
    end
    check("flush_no_ready", ready_cnt, 0);
    check("flush_idle", {dbg_state, bus_cyc}, 0);
    ack_dly = 0;
    push_if(32'h0000_0044);
    if_txn(32'h0000_0044, 32'h0000_0044 ^ KEY, l1);
    check("post_flush_lat", l1, 2);

    // flush held in IDLE blocks any grant
    if_addr = 32'h0000_0048; if_req = 1'b1; flush = 1'b1;
    cyc_cnt = 0;
    repeat (3) begin @(posedge clk); #2; if (bus_cyc) cyc_cnt++; end
    check("flush_idle_nogrant", {cyc_cnt, dbg_state}, 0);
    flush = 1'b0;
    push_if(32'h0000_0048);
    if_txn(32'h0000_0048, 32'h0000_0048 ^ KEY, l1);
    check("flush_idle_release_lat", l1, 2);

    // reset mid BUSY_MEM, then stray acks in IDLE
    slave_en = 1'b0;
    mem_we = 1'b1; mem_sel = 4'hC; mem_addr = 32'h0000_0500; mem_wdata = 32'hCAFE_0000;
    mem_req = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!bus_cyc && n < 20);
    check("rst_busy_mem", dbg_state, 2'd2);
    #1 rst = 1'b0;
    #1 check("rst_async_cyc_stb", {bus_cyc, bus_stb}, 0);
    check("rst_mid_outputs", {bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata,
                              if_rdata, mem_rdata, if_ready, mem_ready, stallreq_if,
                              stallreq_mem, dbg_state}, 0);
    mem_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    stray_ack = 1'b1;
    ready_cnt = 0; cyc_cnt = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (if_ready || mem_ready) ready_cnt++;
      if (bus_cyc || dbg_state != 2'd0) cyc_cnt++;
    end
    stray_ack = 1'b0;
    check("stray_ack_no_ready", ready_cnt, 0);
    check("stray_ack_idle", cyc_cnt, 0);
    slave_en = 1'b1;
    push_mem(1'b0, 4'hF, 32'h0000_0600, 32'h0);
    mem_txn(1'b0, 4'hF, 32'h0000_0600, 32'h0, 32'h0000_0600 ^ KEY, 1'b0, l1);
    check("post_reset_lat", l1, 2);

    repeat (2) @(posedge clk);
    check("bus_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width of all address ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; byte-select width is DATA_W/8.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  pipeline flush from the pipeline controller.
REQ-006 The block SHALL have port if_req  input  1  fetch read request, held until if_ready.
REQ-007 The block SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-008 The block SHALL have ports if_rdata  output  DATA_W  fetched word, and if_ready  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have port mem_req  input  1  load/store request, held until mem_ready.
REQ-010 The block SHALL have ports mem_we  input  1, mem_sel  input  DATA_W/8, mem_addr  input  ADDR_W, mem_wdata  input  DATA_W, carrying write enable, byte select, address and write data.
REQ-011 The block SHALL have ports mem_rdata  output  DATA_W  load data, and mem_ready  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have ports bus_cyc, bus_stb, bus_we  output  1 each; bus_sel  output  DATA_W/8; bus_addr  output  ADDR_W; bus_wdata  output  DATA_W; all forming the shared slave bus request.
REQ-013 The block SHALL have ports bus_rdata  input  DATA_W  and bus_ack  input  1  as the slave response.
REQ-014 The block SHALL have ports stallreq_if  output  1  and stallreq_mem  output  1  as stall requests to the pipeline controller.

Function
REQ-015 The block SHALL implement states IDLE, BUSY_IF, BUSY_MEM, RESP, with a registered owner flag (IF/MEM) and a registered discard flag.
REQ-016 In IDLE with flush=0, the block SHALL grant MEM if mem_req=1, else IF if if_req=1; exception: when the IF-loss counter equals 2 and if_req=1, IF SHALL be granted.
REQ-017 The IF-loss counter (2 bits, saturating at 2) SHALL increment on each MEM grant while if_req=1, and clear on each IF grant.
REQ-018 In IDLE with flush=1, the block SHALL grant nothing and remain in IDLE.
REQ-019 On grant at cycle N, the block SHALL register the requester's address/we/sel/wdata (IF: we=0, sel all ones, wdata 0) and assert bus_cyc=bus_stb=1 from cycle N+1.
REQ-020 In BUSY_*, the block SHALL hold all bus_* outputs stable until bus_ack=1.
REQ-021 On bus_ack=1 at cycle M, the block SHALL capture bus_rdata into the owner's rdata register, deassert bus_cyc/bus_stb at M+1, and enter RESP.
REQ-022 In RESP (one cycle), the owner's ready SHALL be 1 if discard=0 and flush=0; the block then returns to IDLE with no arbitration in RESP.
REQ-023 flush=1 during BUSY_* or RESP SHALL set discard; the bus transaction SHALL complete normally (never aborted mid-cycle), and its ready pulse SHALL be suppressed.
REQ-024 discard SHALL clear on entry to IDLE.
REQ-025 bus_ack while bus_cyc=0 SHALL be ignored.
REQ-026 stallreq_if SHALL equal if_req AND NOT if_ready; stallreq_mem SHALL equal mem_req AND NOT mem_ready (combinational).
REQ-027 if_rdata/mem_rdata SHALL hold their last captured value until the next completion for that requester.
REQ-028 Minimum single-transaction latency SHALL be: request at N, ack at N+1, ready at N+2.

Reset
REQ-029 While rst=0, the block SHALL force state IDLE, owner IF, discard 0, IF-loss counter 0, and all outputs to 0, immediately and independent of clk.
REQ-030 Reset asserted mid-transaction SHALL drop bus_cyc/bus_stb asynchronously; no ready pulse SHALL follow deassertion.

Verification
REQ-031 IF read: if_req=1, if_addr=0x00000100, ack 2 cycles after stb with rdata=0x3C010001 -> if_ready pulse one cycle, if_rdata=0x3C010001, stallreq_if low in the ready cycle.
REQ-032 Simultaneous requests: if_req=mem_req=1, mem store 0x00000200/0xDEADBEEF/sel 0xF -> MEM granted first, bus_we=1, then IF granted after RESP+IDLE.
REQ-033 Fairness: mem_req held continuously with three back-to-back MEM transactions, if_req=1 -> third grant goes to IF.
REQ-034 Flush in BUSY_IF (addr 0x00000040) -> bus_cyc held until ack, no if_ready pulse, IDLE afterwards, next fetch served normally.
REQ-035 Reset mid-BUSY_MEM: rst=0 with bus_cyc=1 -> bus_cyc/stb 0 before next clk edge; later ack ignored; outputs all 0.
REQ-036 Stray bus_ack=1 in IDLE -> no state change, no ready pulse.
